// File: rtl/braid_dispense_pkg.sv
// Shared types for the braid dispense sequencer: FSM states and the
// default command layout held in the command FIFO.
package braid_dispense_pkg;

  localparam int CMD_LANE_W = 2;
  localparam int CMD_VOL_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    PUMP  = 3'd2,
    CLOSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [CMD_LANE_W-1:0] lane;
    logic [CMD_VOL_W-1:0]  volume;
  } cmd_t;

endpackage

// File: rtl/braid_cmd_fifo.sv
// First-word-fall-through command FIFO with a synchronous flush.
// The head entry is visible on pop_data whenever empty is low.
module braid_cmd_fifo
  import braid_dispense_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = cmd_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  push,
  input  item_t push_data,
  input  logic  pop,
  output item_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  item_t       mem_q [DEPTH];

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: flush discards everything, otherwise advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers, cleared asynchronously so a reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/braid_dispense_sequencer.sv
// Valve/pump sequencer feeding the mixer braid lanes. Commands are
// buffered, then executed one at a time: open the lane valve, let it
// settle, issue pump strokes, close and settle, then pulse done.
module braid_dispense_sequencer
  import braid_dispense_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int LANE_W        = 2,
  parameter int VOL_W         = 8,
  parameter int CMD_DEPTH     = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int STROKE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LANE_W-1:0] cmd_lane,
  input  logic [VOL_W-1:0]  cmd_volume,
  input  logic              abort,
  output logic [LANES-1:0]  valve_open,
  output logic              pump_step,
  output logic              busy,
  output logic              done,
  output logic              done_aborted,
  output logic [VOL_W-1:0]  dispensed
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STR_W = $clog2(STROKE_CYCLES);

  // Command layout sized to this instance's lane and volume widths.
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [VOL_W-1:0]  volume;
  } lane_cmd_t;

  lane_cmd_t push_cmd, head_cmd;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop, head_lane_ok;

  state_e           state_q, state_d;
  logic [VOL_W-1:0] vol_q, vol_d, disp_q, disp_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [STR_W-1:0] stroke_q, stroke_d;
  logic [LANES-1:0] valve_q, valve_d;
  logic             pump_q, pump_d, done_q, done_d;
  logic             done_ab_q, done_ab_d, aborted_q, aborted_d;

  // Abort blocks new commands so the flush cannot race a push.
  assign cmd_ready    = rst_n && !fifo_full && !abort;
  assign fifo_push    = cmd_valid && cmd_ready;
  assign push_cmd     = '{lane: cmd_lane, volume: cmd_volume};
  assign fifo_pop     = (state_q == IDLE) && !fifo_empty && !abort;
  assign head_lane_ok = (int'(head_cmd.lane) < LANES);

  braid_cmd_fifo #(
    .DEPTH  (CMD_DEPTH),
    .item_t (lane_cmd_t)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and registered-output logic for the dispense sequence.
  always_comb begin
    state_d   = state_q;
    vol_d     = vol_q;
    disp_d    = disp_q;
    settle_d  = settle_q;
    stroke_d  = stroke_q;
    valve_d   = valve_q;
    aborted_d = aborted_q;
    pump_d    = 1'b0;
    done_d    = 1'b0;
    done_ab_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          vol_d     = head_cmd.volume;
          disp_d    = '0;
          settle_d  = '0;
          aborted_d = 1'b0;
          if (head_cmd.volume == '0 || !head_lane_ok) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = PRIME;
            valve_d = LANES'(1) << head_cmd.lane;
          end
        end
      end
      PRIME: begin
        if (abort) begin
          state_d   = CLOSE;
          valve_d   = '0;
          aborted_d = 1'b1;
          settle_d  = '0;
        end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d  = PUMP;
          stroke_d = '0;
          pump_d   = 1'b1;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      PUMP: begin
        // A stroke pulsed this cycle always counts, even if aborting now.
        disp_d = disp_q + VOL_W'(pump_q);
        if (abort) begin
          state_d   = CLOSE;
          valve_d   = '0;
          aborted_d = 1'b1;
          settle_d  = '0;
        end else if (stroke_q == STR_W'(STROKE_CYCLES - 1)) begin
          if (disp_q == vol_q) begin
            state_d  = CLOSE;
            valve_d  = '0;
            settle_d = '0;
          end else begin
            stroke_d = '0;
            pump_d   = 1'b1;
          end
        end else begin
          stroke_d = stroke_q + STR_W'(1);
        end
      end
      CLOSE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_ab_d = aborted_q;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and outputs; reset closes every valve at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vol_q     <= '0;
      disp_q    <= '0;
      settle_q  <= '0;
      stroke_q  <= '0;
      valve_q   <= '0;
      aborted_q <= 1'b0;
      pump_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ab_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vol_q     <= vol_d;
      disp_q    <= disp_d;
      settle_q  <= settle_d;
      stroke_q  <= stroke_d;
      valve_q   <= valve_d;
      aborted_q <= aborted_d;
      pump_q    <= pump_d;
      done_q    <= done_d;
      done_ab_q <= done_ab_d;
    end
  end

  assign valve_open   = valve_q;
  assign pump_step    = pump_q;
  assign done         = done_q;
  assign done_aborted = done_ab_q;
  assign dispensed    = disp_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/braid_dispense_sequencer.md
Name: braid_dispense_sequencer

Overview:
- Sequential valve/pump controller that meters reagent into the LANES inputs of the fanout-2 mixer braid, directly upstream of it.
- A host queues dispense commands, each naming a lane and a volume in pump strokes.
- The block buffers commands and actuates exactly one lane valve at a time, with settle timing around the pump strokes.
- It reports completion per command and supports abort.

Parameters:
- LANES, 4, number of braid input lanes; valve_open width.
- LANE_W, 2, lane index width; must satisfy 2^LANE_W >= LANES.
- VOL_W, 8, volume field width in strokes.
- CMD_DEPTH, 4, command FIFO depth; power of two, at least 2.
- SETTLE_CYCLES, 4, valve settle time in cycles; at least 1.
- STROKE_CYCLES, 8, cycles per pump stroke; at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_lane  in  LANE_W  target braid input.
- cmd_volume  in  VOL_W  strokes to dispense.
- abort  in  1  level; terminates current command and flushes the FIFO.
- valve_open  out  LANES  one-hot or zero; opens the lane inlet valve.
- pump_step  out  1  one-cycle stroke pulse.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- done  out  1  one-cycle completion pulse.
- done_aborted  out  1  qualifies done: command was aborted.
- dispensed  out  VOL_W  strokes issued for the current or last command.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs 0, except cmd_ready=1 once rst_n is high.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = !fifo_full && !abort.
- Lane validity: a command with cmd_lane >= LANES is accepted and completes as zero-volume, with no valve opened.
- FIFO ordering: first-word-fall-through. Simultaneous push and pop while full is disallowed (cmd_ready=0); push while empty is legal in the same cycle IDLE would pop, and the pop sees it next cycle.
- IDLE: if FIFO is not empty, pop, latch lane and volume, clear dispensed.
  - Volume 0 or invalid lane: go to DONE.
  - Otherwise: go to PRIME, with valve_open[lane]=1 from the next cycle.
- PRIME: hold the valve open for SETTLE_CYCLES cycles, then go to PUMP.
- PUMP: each stroke is STROKE_CYCLES cycles.
  - pump_step=1 in the first cycle of each stroke, and dispensed increments in that same cycle (visible the next cycle).
  - After the last stroke's final cycle, go to CLOSE.
- CLOSE: valve_open=0 for SETTLE_CYCLES cycles, then go to DONE.
- DONE: one cycle with done=1, done_aborted as latched. Then return to IDLE.
- Command timing: total cycles from the pop cycle to the done cycle inclusive = 2 + 2*SETTLE + V*STROKE.
- Back-to-back commands: the next pop occurs in the IDLE cycle after DONE, so there is a minimum 1-cycle IDLE gap between commands.
- Abort, sampled each cycle:
  - In PRIME or PUMP: valve_open drops the next cycle, state becomes CLOSE with done_aborted latched, and no further pump_step is issued. A stroke already pulsed counts in dispensed.
  - In CLOSE or DONE: the current command completes normally and is not flagged aborted.
  - In any state: the FIFO is flushed the same cycle. The aborted command's done still fires after CLOSE. Flushed commands produce no done.
- Invariants:
  - At most one valve_open bit is set.
  - pump_step is asserted only while valve_open is nonzero.
  - dispensed saturates at most at the latched volume.
- Reset mid-operation: all valves close immediately (async), and the FIFO empties.

Decomposition:
- Package braid_dispense_pkg: FSM state enum (IDLE, PRIME, PUMP, CLOSE, DONE) and a command struct {lane, volume}.
- One sub-module, braid_cmd_fifo: a parameterised synchronous FIFO with a flush input, holding command structs.
- Counters (settle, stroke, volume) stay inline in the top module.

Test Plan:
- Basic dispense: after reset, push {lane=2, vol=3} → valve_open=4'b0100 for 4+24 cycles; 3 pump_step pulses 8 cycles apart; valve closes; done 4 cycles later; dispensed=3; 34 cycles from pop to done.
- FIFO backpressure: push 5 commands {lane=0..3,0} each vol=1 with no stall → cmd_ready=0 after 4 are buffered (one popped, so the 5th accepted on the next cycle); 5 done pulses in order; each valve opens exactly once.
- Zero volume: push {lane=1, vol=0}, then {lane=3, vol=0} → done 2 cycles after each pop; valve_open and pump_step never assert.
- Abort mid-pump: push {lane=0, vol=10}, assert abort 1 cycle after the 2nd pump_step, with 2 commands queued → valve closes the next cycle; done with done_aborted=1 after 4 cycles; dispensed=2; FIFO empty; busy=0 afterwards.
- Reset mid-operation: drop rst_n during PUMP → valve_open, pump_step, busy go to 0 asynchronously; after release, cmd_ready=1 and no spurious done.
- Invalid lane: push {lane=3} with LANES=3 → done after 2 cycles; no valve activity.
